// File: rtl/dht11_sensor_model.sv
// dht11_sensor_model
//   Sensor-side responder for the DHT11 single-wire protocol. It waits for a
//   host start pulse on the shared line, then sends the response preamble,
//   40 data bits (hum_int, hum_dec, temp_int, temp_dec, checksum; MSB first)
//   and the closing low pulse. Runs on a 1 MHz clock (1 cycle = 1 us).
//   The line is open-drain: the top level pulls dht11_data low while
//   drive_low=1 and leaves it floating otherwise.
//
// Ports
//   clk        divided system clock (1 MHz)
//   rst        asynchronous reset, active-high
//   bus_in     raw dht11_data line, asynchronous to clk
//   hum_int    humidity integer byte
//   hum_dec    humidity decimal byte
//   temp_int   temperature integer byte
//   temp_dec   temperature decimal byte
//   drive_low  1 = pull line low, 0 = release
//   busy       high from start accepted until the line is seen released
//   frame_done one-cycle pulse when the closing low pulse completes
//
// States
//   state     | meaning
//   S_IDLE    | measure host low time on bus_s, wait for release after a long low
//   S_WAIT    | line released, delay before the response
//   S_RESP_L  | response low pulse
//   S_RESP_H  | response high (released) time
//   S_BIT_L   | low time preceding a data bit
//   S_BIT_H   | released time; its length encodes the current bit
//   S_END_L   | closing low pulse after bit 39
//   S_RELEASE | wait for the synchronized line to read high again

module dht11_sensor_model #(
    parameter int unsigned START_MIN = 18000,
    parameter int unsigned RESP_WAIT = 30,
    parameter int unsigned RESP_LOW  = 80,
    parameter int unsigned RESP_HIGH = 80,
    parameter int unsigned BIT_LOW   = 50,
    parameter int unsigned BIT0_HIGH = 26,
    parameter int unsigned BIT1_HIGH = 70,
    parameter int unsigned END_LOW   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_in,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       drive_low,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RESP_L, S_RESP_H, S_BIT_L, S_BIT_H, S_END_L, S_RELEASE
    } state_t;

    // Phase lengths are loaded as N-1 so each phase lasts exactly N cycles
    // and ends on the terminal count of zero.
    localparam logic [14:0] START_MIN_C = 15'(START_MIN);
    localparam logic [14:0] RESP_WAIT_LD = 15'(RESP_WAIT - 1);
    localparam logic [14:0] RESP_LOW_LD  = 15'(RESP_LOW - 1);
    localparam logic [14:0] RESP_HIGH_LD = 15'(RESP_HIGH - 1);
    localparam logic [14:0] BIT_LOW_LD   = 15'(BIT_LOW - 1);
    localparam logic [14:0] BIT0_HIGH_LD = 15'(BIT0_HIGH - 1);
    localparam logic [14:0] BIT1_HIGH_LD = 15'(BIT1_HIGH - 1);
    localparam logic [14:0] END_LOW_LD   = 15'(END_LOW - 1);

    state_t      state, state_nxt;
    logic [14:0] cnt, cnt_nxt;
    logic [5:0]  bit_cnt, bit_cnt_nxt;
    logic [39:0] shift_reg, shift_reg_nxt;
    logic        frame_done_nxt;
    logic        bus_m, bus_s;
    logic [7:0]  chk;
    logic        phase_end;

    assign chk       = hum_int + hum_dec + temp_int + temp_dec;
    assign phase_end = (cnt == 15'd0);
    assign busy      = (state != S_IDLE);

    // Synchronizer resets to the idle (pulled-up) level so reset itself
    // never looks like the start of a host low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_m <= 1'b1;
            bus_s <= 1'b1;
        end else begin
            bus_m <= bus_in;
            bus_s <= bus_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 15'd0;
            bit_cnt    <= 6'd0;
            shift_reg  <= 40'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_reg_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // In S_IDLE cnt counts host low time upward; in every other state it
    // is the phase down-counter.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bit_cnt_nxt    = bit_cnt;
        shift_reg_nxt  = shift_reg;
        frame_done_nxt = 1'b0;
        drive_low      = 1'b0;

        case (state)
            S_IDLE: begin
                if (!bus_s) begin
                    if (cnt != START_MIN_C) cnt_nxt = cnt + 15'd1;
                end else if (cnt == START_MIN_C) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = RESP_WAIT_LD;
                end else begin
                    cnt_nxt = 15'd0;
                end
            end
            S_WAIT: begin
                if (phase_end) begin
                    state_nxt     = S_RESP_L;
                    cnt_nxt       = RESP_LOW_LD;
                    shift_reg_nxt = {hum_int, hum_dec, temp_int, temp_dec, chk};
                    bit_cnt_nxt   = 6'd0;
                end else begin
                    cnt_nxt = cnt - 15'd1;
                end
            end
            S_RESP_L: begin
                drive_low = 1'b1;
                if (phase_end) begin
                    state_nxt = S_RESP_H;
                    cnt_nxt   = RESP_HIGH_LD;
                end else begin
                    cnt_nxt = cnt - 15'd1;
                end
            end
            S_RESP_H: begin
                if (phase_end) begin
                    state_nxt = S_BIT_L;
                    cnt_nxt   = BIT_LOW_LD;
                end else begin
                    cnt_nxt = cnt - 15'd1;
                end
            end
            S_BIT_L: begin
                drive_low = 1'b1;
                if (phase_end) begin
                    state_nxt = S_BIT_H;
                    cnt_nxt   = shift_reg[39] ? BIT1_HIGH_LD : BIT0_HIGH_LD;
                end else begin
                    cnt_nxt = cnt - 15'd1;
                end
            end
            S_BIT_H: begin
                if (phase_end) begin
                    shift_reg_nxt = {shift_reg[38:0], 1'b0};
                    bit_cnt_nxt   = bit_cnt + 6'd1;
                    if (bit_cnt == 6'd39) begin
                        state_nxt = S_END_L;
                        cnt_nxt   = END_LOW_LD;
                    end else begin
                        state_nxt = S_BIT_L;
                        cnt_nxt   = BIT_LOW_LD;
                    end
                end else begin
                    cnt_nxt = cnt - 15'd1;
                end
            end
            S_END_L: begin
                drive_low = 1'b1;
                if (phase_end) begin
                    state_nxt      = S_RELEASE;
                    cnt_nxt        = 15'd0;
                    frame_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 15'd1;
                end
            end
            S_RELEASE: begin
                // Our own closing low is still in the synchronizer; leaving
                // only on a high keeps it from counting as a host start.
                cnt_nxt = 15'd0;
                if (bus_s) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 15'd0;
            end
        endcase
    end

endmodule
